// File: rtl/wave_analyzer.sv
// Period and peak-amplitude analyzer for a signed 32-bit sample stream.
// Rising zero crossings are found with a hysteresis band; one result is produced per full cycle.
module wave_analyzer #(
    parameter logic [30:0] HYST       = 31'd1000000,
    parameter logic [25:0] MAX_PERIOD = 26'h3FFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [31:0] sample,
    output logic [25:0] period,
    output logic [31:0] peak,
    output logic        result_valid,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t      state_q;
    logic [25:0] cnt_q;
    logic [30:0] acc_q;
    logic [25:0] period_q;
    logic [30:0] peak_q;
    logic        result_valid_q;
    logic        timeout_q;
    logic        locked_q;

    logic signed [32:0] sample_ext;
    logic signed [32:0] hyst_pos;
    logic signed [32:0] hyst_neg;
    logic               is_high;
    logic               is_low;
    logic        [32:0] abs_full;
    logic        [30:0] abs_sat;
    logic        [30:0] acc_d;
    logic        [25:0] cnt_d;
    logic               cnt_last;
    logic               rising;

    assign sample_ext = {sample[31], sample};
    assign hyst_pos   = $signed({2'b00, HYST});
    assign hyst_neg   = -hyst_pos;

    // Samples exactly on +/-HYST fall inside the band and keep the current polarity.
    assign is_high = sample_valid && (sample_ext > hyst_pos);
    assign is_low  = sample_valid && (sample_ext < hyst_neg);

    // Only -2^31 produces a magnitude of 2^31; clamp it into the 31-bit accumulator.
    assign abs_full = sample[31] ? (33'd0 - sample_ext) : sample_ext;
    assign abs_sat  = (abs_full[32] | abs_full[31]) ? 31'h7FFF_FFFF : abs_full[30:0];
    assign acc_d    = (abs_sat > acc_q) ? abs_sat : acc_q;
    assign cnt_d    = cnt_q + 26'd1;

    assign cnt_last = (cnt_q == MAX_PERIOD - 26'd1);
    assign rising   = (state_q == ST_LOW) && is_high;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            period_q       <= '0;
            peak_q         <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (!enable) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                acc_q    <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        locked_q <= 1'b0;
                        if (is_low) begin
                            state_q <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (is_high) begin
                            state_q  <= ST_HIGH;
                            cnt_q    <= '0;
                            acc_q    <= abs_sat;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_HIGH, ST_LOW: begin
                        // A crossing on the last counted cycle still wins over the timeout.
                        if (rising) begin
                            state_q        <= ST_HIGH;
                            period_q       <= cnt_d;
                            peak_q         <= acc_q;
                            result_valid_q <= 1'b1;
                            cnt_q          <= '0;
                            acc_q          <= abs_sat;
                        end else if (cnt_last) begin
                            state_q   <= ST_IDLE;
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            acc_q     <= '0;
                            locked_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                            if (sample_valid) begin
                                acc_q <= acc_d;
                            end
                            if (is_low) begin
                                state_q <= ST_LOW;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period       = period_q;
    assign peak         = {1'b0, peak_q};
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// Bench for wave_analyzer: fixed vectors, directed waveforms and random traffic
// compared against an event-level model built from crossing times and sample magnitudes.
module tb_wave_analyzer;
    localparam longint HYST_L = 1000000;
    localparam longint MAXP_L = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [31:0] sample;
    logic [25:0] period;
    logic [31:0] peak;
    logic        result_valid;
    logic        timeout;
    logic        locked;

    wave_analyzer #(
        .HYST      (31'd1000000),
        .MAX_PERIOD(26'd100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .sample      (sample),
        .period      (period),
        .peak        (peak),
        .result_valid(result_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Model: polarity of the last decisive sample (0 unknown, -1 low, +1 high),
    // time of the last rising crossing, and every valid magnitude since it.
    longint t_now      = 0;
    longint last_cross = 0;
    int     pol        = 0;
    bit     m_locked   = 1'b0;
    longint mags[$];
    bit     m_rv       = 1'b0;
    bit     m_to       = 1'b0;
    longint m_period   = 0;
    longint m_peak     = 0;

    typedef struct packed {
        logic        en;
        logic        v;
        logic [31:0] s;
        logic        rv;
        logic [25:0] per;
        logic [31:0] pk;
        logic        lk;
    } vec_t;

    function automatic logic [31:0] s32(input longint x);
        return x[31:0];
    endfunction

    function automatic longint mag_of(input logic [31:0] s);
        longint v;
        v = longint'($signed(s));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 2147483647;
        return v;
    endfunction

    function automatic vec_t mkv(input logic en, input logic v, input logic [31:0] s, input logic rv,
                                 input logic [25:0] per, input logic [31:0] pk, input logic lk);
        vec_t r;
        r.en = en; r.v = v; r.s = s; r.rv = rv; r.per = per; r.pk = pk; r.lk = lk;
        return r;
    endfunction

    task automatic model_update(input logic rst, input logic en, input logic v, input logic [31:0] s);
        longint sv;
        longint mx;
        bit     hi;
        bit     lo;
        t_now++;
        m_rv = 1'b0;
        m_to = 1'b0;
        sv = longint'($signed(s));
        hi = v && (sv > HYST_L);
        lo = v && (sv < -HYST_L);
        if (rst || !en) begin
            pol = 0;
            m_locked = 1'b0;
            mags.delete();
            if (rst) begin
                m_period = 0;
                m_peak = 0;
            end
        end else if (hi && pol == -1) begin
            if (m_locked) begin
                mx = 0;
                foreach (mags[i]) if (mags[i] > mx) mx = mags[i];
                m_period = t_now - last_cross;
                m_peak = mx;
                m_rv = 1'b1;
            end
            m_locked = 1'b1;
            last_cross = t_now;
            mags.delete();
            mags.push_back(mag_of(s));
            pol = 1;
        end else if (m_locked && (t_now - last_cross == MAXP_L)) begin
            m_to = 1'b1;
            m_locked = 1'b0;
            pol = 0;
            mags.delete();
        end else begin
            if (lo) pol = -1;
            if (m_locked && v) mags.push_back(mag_of(s));
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t_now);
    endtask

    task automatic check_model(input string tag);
        check({tag, " result_valid"}, longint'(result_valid), longint'(m_rv));
        check({tag, " timeout"}, longint'(timeout), longint'(m_to));
        check({tag, " locked"}, longint'(locked), longint'(m_locked));
        check({tag, " period"}, longint'(period), m_period);
        check({tag, " peak"}, longint'(peak), m_peak);
    endtask

    task automatic step(input logic rst, input logic en, input logic v, input logic [31:0] s);
        reset = rst;
        enable = en;
        sample_valid = v;
        sample = s;
        @(posedge clock);
        #1;
        model_update(rst, en, v, s);
        if (result_valid) $display("t=%0d result period=%0d peak=%0d", t_now, period, peak);
        if (timeout) $display("t=%0d timeout", t_now);
    endtask

    initial begin
        vec_t        tbl[16];
        int          rv_cnt;
        int          k;
        int          r;
        int          half_left;
        int          lvl;
        longint      base;
        longint      amp;
        bit          hi_half;
        bit          v_r;
        bit          en_r;
        bit          rst_r;
        logic [31:0] s_r;

        // en, valid, sample, expected result_valid/period/peak/locked after the edge
        tbl[0]  = mkv(1'b1, 1'b1, s32(-2000000),  1'b0, 26'd0, 32'd0,          1'b0);
        tbl[1]  = mkv(1'b1, 1'b1, s32(3000000),   1'b0, 26'd0, 32'd0,          1'b1);
        tbl[2]  = mkv(1'b1, 1'b1, s32(-2500000),  1'b0, 26'd0, 32'd0,          1'b1);
        tbl[3]  = mkv(1'b1, 1'b1, s32(2000000),   1'b1, 26'd2, 32'd3000000,    1'b1);
        tbl[4]  = mkv(1'b1, 1'b1, 32'h8000_0000,  1'b0, 26'd2, 32'd3000000,    1'b1);
        tbl[5]  = mkv(1'b1, 1'b1, 32'd0,          1'b0, 26'd2, 32'd3000000,    1'b1);
        tbl[6]  = mkv(1'b1, 1'b1, s32(1500000),   1'b1, 26'd3, 32'd2147483647, 1'b1);
        tbl[7]  = mkv(1'b1, 1'b1, s32(1000000),   1'b0, 26'd3, 32'd2147483647, 1'b1);
        tbl[8]  = mkv(1'b1, 1'b1, s32(-1000000),  1'b0, 26'd3, 32'd2147483647, 1'b1);
        tbl[9]  = mkv(1'b1, 1'b1, s32(1500000),   1'b0, 26'd3, 32'd2147483647, 1'b1);
        tbl[10] = mkv(1'b1, 1'b1, s32(-1200000),  1'b0, 26'd3, 32'd2147483647, 1'b1);
        tbl[11] = mkv(1'b1, 1'b1, s32(1100000),   1'b1, 26'd5, 32'd1500000,    1'b1);
        tbl[12] = mkv(1'b0, 1'b1, s32(2000000),   1'b0, 26'd5, 32'd1500000,    1'b0);
        tbl[13] = mkv(1'b1, 1'b1, s32(2000000),   1'b0, 26'd5, 32'd1500000,    1'b0);
        tbl[14] = mkv(1'b1, 1'b0, s32(-2000000),  1'b0, 26'd5, 32'd1500000,    1'b0);
        tbl[15] = mkv(1'b1, 1'b1, s32(3000000),   1'b0, 26'd5, 32'd1500000,    1'b0);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, s32(-3000000));
        check("reset period", longint'(period), 0);
        check("reset peak", longint'(peak), 0);
        check("reset result_valid", longint'(result_valid), 0);
        check("reset timeout", longint'(timeout), 0);
        check("reset locked", longint'(locked), 0);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, tbl[i].en, tbl[i].v, tbl[i].s);
            check($sformatf("vec%0d result_valid", i), longint'(result_valid), longint'(tbl[i].rv));
            check($sformatf("vec%0d period", i), longint'(period), longint'(tbl[i].per));
            check($sformatf("vec%0d peak", i), longint'(peak), longint'(tbl[i].pk));
            check($sformatf("vec%0d locked", i), longint'(locked), longint'(tbl[i].lk));
            check($sformatf("vec%0d timeout", i), longint'(timeout), 0);
        end

        // Square wave +/-5000000, 8 cycles per half
        rv_cnt = 0;
        for (int c = 0; c < 96; c++) begin
            step(1'b0, 1'b1, 1'b1, (c % 16 < 8) ? s32(-5000000) : s32(5000000));
            check_model("square");
            if (c >= 8) check("square locked", longint'(locked), 1);
            if (result_valid) begin
                rv_cnt++;
                check("square period", longint'(period), 16);
                check("square peak", longint'(peak), 5000000);
            end
        end
        check("square results", rv_cnt, 5);

        // Triangle +/-100000000, 64-cycle period, noise near zero
        rv_cnt = 0;
        for (int c = 0; c < 320; c++) begin
            k = c % 64;
            base = (k < 32) ? longint'(-100000000 + 6250000 * k) : longint'(100000000 - 6250000 * (k - 32));
            if (base <= 6250000 && base >= -6250000)
                base = base + longint'($urandom_range(0, 1000000)) - 500000;
            step(1'b0, 1'b1, 1'b1, s32(base));
            check_model("triangle");
            if (result_valid) begin
                if (rv_cnt > 0) begin
                    check("triangle period", longint'(period), 64);
                    check("triangle peak", longint'(peak), 100000000);
                end
                rv_cnt++;
            end
        end
        check("triangle results", rv_cnt, 5);

        // Lock then stick high until the period counter runs out
        step(1'b0, 1'b0, 1'b1, s32(-5000000));
        check_model("to disable");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, s32(-5000000));
            check_model("to arm");
        end
        step(1'b0, 1'b1, 1'b1, s32(5000000));
        check_model("to lock");
        check("to lock locked", longint'(locked), 1);
        for (int j = 1; j <= 105; j++) begin
            step(1'b0, 1'b1, 1'b1, s32(5000000));
            check_model("stuck");
            check($sformatf("stuck%0d timeout", j), longint'(timeout), longint'(j == 100));
            check($sformatf("stuck%0d locked", j), longint'(locked), longint'(j < 100));
            check("stuck period", longint'(period), 64);
            check("stuck peak", longint'(peak), 100000000);
            check("stuck result_valid", longint'(result_valid), 0);
        end

        // Gated samples: only every other cycle valid, invalid spikes ignored
        rv_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            hi_half = ((c / 8) % 2) == 1;
            v_r = (c % 2) == 0;
            if (v_r) s_r = hi_half ? s32(3000000) : s32(-3000000);
            else     s_r = hi_half ? 32'h8000_0000 : 32'h7FFF_FFFF;
            step(1'b0, 1'b1, v_r, s_r);
            check_model("gated");
            if (result_valid) begin
                rv_cnt++;
                check("gated period", longint'(period), 16);
                check("gated peak", longint'(peak), 3000000);
            end
        end
        check("gated results", rv_cnt, 4);

        // Enable dropped mid-period, then a full relock is required
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, s32(5000000));
            check_model("disabled");
            check("disabled locked", longint'(locked), 0);
            check("disabled result_valid", longint'(result_valid), 0);
        end
        rv_cnt = 0;
        for (int c = 0; c < 29; c++) begin
            hi_half = (c < 5) || (c >= 13 && c < 21);
            step(1'b0, 1'b1, 1'b1, hi_half ? s32(5000000) : s32(-5000000));
            check_model("reenable");
            if (result_valid) rv_cnt++;
        end
        check("reenable early results", rv_cnt, 0);
        step(1'b0, 1'b1, 1'b1, s32(5000000));
        check_model("reenable first");
        check("reenable result_valid", longint'(result_valid), 1);
        check("reenable period", longint'(period), 16);
        check("reenable peak", longint'(peak), 5000000);

        // Reset mid-measurement
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, s32(5000000));
            check_model("pre-reset");
        end
        step(1'b1, 1'b1, 1'b1, s32(-5000000));
        check_model("mid reset");
        check("mid reset period", longint'(period), 0);
        check("mid reset peak", longint'(peak), 0);
        check("mid reset locked", longint'(locked), 0);
        check("mid reset timeout", longint'(timeout), 0);
        check("mid reset result_valid", longint'(result_valid), 0);

        // Random traffic
        half_left = 0;
        lvl = 1;
        amp = 2000000;
        for (int n = 0; n < 3000; n++) begin
            if (half_left == 0) begin
                lvl = -lvl;
                half_left = int'($urandom_range(1, 60));
                amp = longint'($urandom_range(1000001, 32'h7FFF_FFFF));
            end
            half_left--;
            r = int'($urandom_range(0, 99));
            if (r < 5)                     s_r = $urandom();
            else if (r < 15)               s_r = s32(longint'($urandom_range(0, 2000000)) - 1000000);
            else if (r == 15 && lvl < 0)   s_r = 32'h8000_0000;
            else                           s_r = s32(longint'(lvl) * amp);
            v_r   = $urandom_range(0, 9) != 0;
            en_r  = $urandom_range(0, 199) != 0;
            rst_r = $urandom_range(0, 499) == 0;
            step(rst_r, en_r, v_r, s_r);
            check_model("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wave_analyzer.md
# wave_analyzer

Measures the period and peak amplitude of the signed 32-bit audio sample stream that the waveform generators produce, recovering the same quantities a generator is configured with. It sits on the generator output bus and feeds status and debug logic. Rising zero crossings are detected with hysteresis. For each full cycle it reports the crossing-to-crossing period in clock cycles and the peak absolute sample value.

## Interface
- HYST, 1000000: hysteresis threshold (unsigned 31-bit).
  - A sample is "high" when > +HYST and "low" when < -HYST.
  - The band in between holds the current polarity.
- MAX_PERIOD, 26'h3FFFFFF: period counter limit in clock cycles. Reaching it without a crossing is a timeout.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  analyzer enable. Low forces IDLE and clears the counter and peak accumulator.
- sample_valid  in  1  qualifies `sample` this cycle.
- sample  in  32  signed two's-complement audio sample.
- period  out  26  last measured period in clock cycles. Holds until the next result.
- peak  out  32  last measured peak |sample|. Unsigned, saturated at 2^31-1.
- result_valid  out  1  one-cycle pulse when `period`/`peak` update.
- timeout  out  1  one-cycle pulse when a measurement is abandoned.
- locked  out  1  high in states HIGH and LOW.

## Operation
- FSM states: IDLE, ARM, HIGH, LOW.
  - Only cycles with sample_valid=1 evaluate thresholds.
  - The counter advances every clock regardless of sample_valid.
- IDLE -> ARM on a low sample.
- ARM -> HIGH on a high sample (first rising crossing). Action: cnt<=0, acc<=|sample|. No result is emitted.
- HIGH -> LOW on a low sample.
- LOW -> HIGH on a high sample (rising crossing):
  - period<=cnt+1 and peak<=max(acc,|sample_prev_samples|). The crossing sample itself is excluded; it belongs to the next cycle.
  - result_valid pulses.
  - cnt<=0, acc<=|sample|.
- In HIGH/LOW, every valid non-crossing sample updates acc<=max(acc,|sample|).
- Timeout: in HIGH/LOW, when cnt==MAX_PERIOD-1 and no crossing occurs this cycle:
  - go to IDLE and pulse timeout;
  - period/peak keep their old values.
- Crossing and timeout in the same cycle: the crossing wins.
- Absolute value: |s| = s<0 ? -s : s, computed in 33 bits.
  - -2^31 saturates to 2^31-1.
  - acc is 31 bits, zero-extended on `peak`.
- enable low: next state IDLE, cnt<=0, acc<=0, no pulses. period/peak hold.
- Samples within ±HYST, including exactly ±HYST, never change polarity.

## Timing
- Reset values: period=0, peak=0, result_valid=0, timeout=0, locked=0, state=IDLE, cnt=0, acc=0.
- Latency: a crossing sample in cycle N gives result_valid=1 in cycle N+1. period/peak are valid in that same cycle.
- Crossings at cycles N and N+P report period=P.
- All outputs are registered. No combinational input-to-output paths.
- Reset mid-measurement aborts with no result and no timeout pulse.
- Minimum reportable period is 2: the low and high samples fall on consecutive cycles.

## Test plan
- Square stream, sample_valid=1, alternating ±5000000 every 8 cycles:
  - result_valid pulses every 16 cycles with period=16, peak=5000000;
  - locked=1 from the first rising crossing onward.
- Triangle peaking at ±100000000 with 64-cycle period, plus ±500000 noise near zero:
  - no extra crossings;
  - period=64 and peak=100000000 every cycle.
- Sample=-2^31 inside a period -> peak=2147483647 at the next result.
- MAX_PERIOD=100, signal stuck high after lock:
  - timeout pulses exactly 100 cycles after the last crossing;
  - state returns to IDLE, locked=0;
  - period/peak unchanged.
- sample_valid toggling 1/0, square of 4 valid samples per half:
  - period=16 clock cycles;
  - samples with valid=0 (e.g. a -2^31 spike) are ignored.
- enable deasserted mid-period, then reasserted:
  - no result until a new ARM->HIGH lock plus one full cycle;
  - reset asserted mid-period -> all outputs return to 0 next cycle.
